distance_averager: RTL and testbench

- Upstream conditioning stage for the AM PWM DAC.
- Takes raw distance samples through a valid/ready handshake and saturates each one to the DAC's distance range.
- Keeps a moving average over a 2^LOG2_DEPTH sample window and presents a held, registered distance word on the DAC's distance input.
- Removes sample-to-sample jitter so the AM envelope does not flicker at the carrier rate.

---
 rtl/distance_averager.sv | 117 +++++++++++
 tb/tb_distance_averager.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/distance_averager.sv
// Moving-average conditioner for the AM PWM DAC distance input: saturates accepted
// samples, averages the last 2**LOG2_DEPTH of them and holds the result in a register.
module distance_averager #(
   parameter int WIDTH         = 13,
   parameter int LOG2_DEPTH    = 4,
   parameter int LOG2_MAX_DIST = 11,
   parameter int SUM_WIDTH     = WIDTH + LOG2_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] sample_in,
   input  logic             sample_valid,
   output logic             sample_ready,
   output logic [WIDTH-1:0] distance,
   output logic             distance_valid
);

   localparam int DEPTH = 2 ** LOG2_DEPTH;
   localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(2 ** LOG2_MAX_DIST - 1);

   typedef enum logic [1:0] {CLEAR, PRIME, RUN} state_t;

   state_t                state_q, state_d;
   logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LOG2_DEPTH:0]   count_q, count_d;
   logic [SUM_WIDTH-1:0]  sum_q, sum_d;
   logic [WIDTH-1:0]      distance_q, distance_d;
   logic                  dvalid_q, dvalid_d;
   logic                  upd_q, upd_d;

   logic [WIDTH-1:0]      win_mem [DEPTH];
   logic [WIDTH-1:0]      oldest;
   logic [WIDTH-1:0]      sat_sample;
   logic [WIDTH-1:0]      mem_wdata;
   logic                  mem_we;
   logic                  accept;

   assign sample_ready   = enable && (state_q != CLEAR);
   assign accept         = sample_valid && sample_ready;
   assign sat_sample     = (sample_in > SAT_MAX) ? SAT_MAX : sample_in;
   // Small window: asynchronous read so the oldest entry is retired in the accept cycle.
   assign oldest         = win_mem[wr_ptr_q];
   assign distance       = distance_q;
   assign distance_valid = dvalid_q;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      sum_d      = sum_q;
      distance_d = distance_q;
      dvalid_d   = dvalid_q;
      upd_d      = upd_q;
      mem_we     = 1'b0;
      mem_wdata  = '0;
      if (enable) begin
         if (upd_q) begin
            distance_d = sum_q[SUM_WIDTH-1:LOG2_DEPTH];
            dvalid_d   = dvalid_q || (state_q == RUN);
            upd_d      = 1'b0;
         end
         case (state_q)
            CLEAR: begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (wr_ptr_q == LOG2_DEPTH'(DEPTH - 1)) begin
                  state_d = PRIME;
               end
            end
            PRIME, RUN: begin
               if (accept) begin
                  mem_we    = 1'b1;
                  mem_wdata = sat_sample;
                  sum_d     = sum_q + SUM_WIDTH'(sat_sample) - SUM_WIDTH'(oldest);
                  wr_ptr_d  = wr_ptr_q + 1'b1;
                  upd_d     = 1'b1;
                  if (state_q == PRIME) begin
                     count_d = count_q + 1'b1;
                     if (count_q == (LOG2_DEPTH + 1)'(DEPTH - 1)) begin
                        state_d = RUN;
                     end
                  end
               end
            end
            default: state_d = CLEAR;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= CLEAR;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         sum_q      <= '0;
         distance_q <= '0;
         dvalid_q   <= 1'b0;
         upd_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         sum_q      <= sum_d;
         distance_q <= distance_d;
         dvalid_q   <= dvalid_d;
         upd_q      <= upd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && mem_we) begin
         win_mem[wr_ptr_q] <= mem_wdata;
      end
   end

endmodule

// File: tb/tb_distance_averager.sv
// Directed plus randomized bench for distance_averager against a queue-based window model.
module tb_distance_averager;

   localparam int WIDTH = 13;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic [WIDTH-1:0] sample_in;
   logic             sample_valid;
   logic             sample_ready;
   logic [WIDTH-1:0] distance;
   logic             distance_valid;

   int checks   = 0;
   int failures = 0;

   // Reference model: window of accepted (saturated) samples since reset.
   int win[$];
   int n_acc      = 0;
   int clear_left = 16;
   int exp_dist   = 0;
   bit exp_dv     = 1'b0;
   bit pend       = 1'b0;
   bit last_acc   = 1'b0;
   bit obs_rdy    = 1'b0;

   distance_averager dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .sample_in      (sample_in),
      .sample_valid   (sample_valid),
      .sample_ready   (sample_ready),
      .distance       (distance),
      .distance_valid (distance_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic int window_avg();
      int s;
      s = 0;
      foreach (win[i]) s += win[i];
      return s / 16;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock cycle: check ready before the edge, advance the model at the edge, check outputs after.
   task automatic tick();
      bit rdy_exp;
      int s;
      rdy_exp = enable && (clear_left == 0);
      #1;
      obs_rdy = sample_ready;
      if (!reset) chk("sample_ready", {31'b0, sample_ready}, int'(rdy_exp));
      last_acc = !reset && rdy_exp && sample_valid;
      s = (sample_in > 2047) ? 2047 : int'(sample_in);
      @(posedge clk);
      #1;
      if (reset) begin
         win.delete();
         n_acc      = 0;
         clear_left = 16;
         exp_dist   = 0;
         exp_dv     = 1'b0;
         pend       = 1'b0;
      end else if (enable) begin
         if (pend) begin
            exp_dist = window_avg();
            exp_dv   = exp_dv || (n_acc >= 16);
            pend     = 1'b0;
         end
         if (clear_left > 0) clear_left--;
         if (last_acc) begin
            win.push_back(s);
            if (win.size() > 16) void'(win.pop_front());
            n_acc++;
            pend = 1'b1;
            $display("accept #%0d sample_in=%0d saturated=%0d", n_acc, sample_in, s);
         end
      end
      chk("distance", 32'(distance), exp_dist);
      chk("distance_valid", {31'b0, distance_valid}, int'(exp_dv));
   endtask

   task automatic feed(int val, int n, int gap);
      int guard;
      for (int i = 0; i < n; i++) begin
         guard        = 0;
         sample_in    = WIDTH'(val);
         sample_valid = 1'b1;
         do begin
            tick();
            guard++;
         end while (!last_acc && guard < 200);
         chk("accept_within_bound", {31'b0, last_acc}, 1);
         sample_valid = 1'b0;
         for (int g = 0; g < gap; g++) tick();
      end
   endtask

   // Holds valid from the end of reset and counts cycles with ready low until the first accept.
   task automatic count_ready_low(int val, output int lows);
      int guard;
      lows         = 0;
      guard        = 0;
      sample_in    = WIDTH'(val);
      sample_valid = 1'b1;
      do begin
         tick();
         if (!obs_rdy) lows++;
         guard++;
      end while (!last_acc && guard < 100);
      chk("first_accept_within_bound", {31'b0, last_acc}, 1);
      sample_valid = 1'b0;
   endtask

   initial begin
      int lows;
      bit holding;
      reset        = 1'b1;
      enable       = 1'b1;
      sample_valid = 1'b0;
      sample_in    = '0;
      tick();
      tick();
      chk("reset_distance", 32'(distance), 0);
      chk("reset_distance_valid", {31'b0, distance_valid}, 0);
      chk("reset_sample_ready", {31'b0, sample_ready}, 0);

      // Prime with 1000: 16 clear cycles, half-window ramp, full window.
      reset = 1'b0;
      count_ready_low(1000, lows);
      chk("clear_ready_low_cycles", 32'(lows), 16);
      feed(1000, 7, 0);
      tick();
      chk("prime_half_distance", 32'(distance), 500);
      chk("prime_half_valid", {31'b0, distance_valid}, 0);
      feed(1000, 8, 0);
      tick();
      chk("full_distance", 32'(distance), 1000);
      chk("full_valid", {31'b0, distance_valid}, 1);

      // Step response to 2000.
      feed(2000, 8, 0);
      tick();
      chk("step_half", 32'(distance), 1500);
      feed(2000, 8, 0);
      tick();
      chk("step_full", 32'(distance), 2000);

      // Enable gating mid-RUN with valid held high.
      enable       = 1'b0;
      sample_in    = WIDTH'(1000);
      sample_valid = 1'b1;
      repeat (10) tick();
      chk("gated_distance", 32'(distance), 2000);
      enable       = 1'b1;
      sample_valid = 1'b0;
      feed(1000, 8, 0);
      tick();
      chk("resume_distance", 32'(distance), 1500);

      // Reset mid-RUN; old window must not leak.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_distance", 32'(distance), 0);
      chk("midrst_valid", {31'b0, distance_valid}, 0);
      count_ready_low(300, lows);
      chk("midrst_ready_low_cycles", 32'(lows), 16);
      feed(300, 15, 0);
      tick();
      chk("midrst_refill", 32'(distance), 300);

      // Saturation, then truncation after a reset.
      feed(5000, 16, 0);
      tick();
      chk("saturation", 32'(distance), 2047);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int v = 0; v < 16; v++) feed(v, 1, 0);
      tick();
      chk("truncation", 32'(distance), 7);
      chk("truncation_valid", {31'b0, distance_valid}, 1);

      // Sparse valid: one pulse every 5th cycle.
      feed(800, 16, 4);
      chk("sparse_distance", 32'(distance), 800);

      // Randomized traffic: random enable, valid held until accepted, one reset midway.
      holding = 1'b0;
      for (int i = 0; i < 400; i++) begin
         enable = ($urandom_range(0, 7) != 0);
         reset  = (i == 200);
         if (!holding) begin
            sample_valid = $urandom_range(0, 1) == 1;
            sample_in    = WIDTH'($urandom_range(0, 8191));
         end
         tick();
         holding = sample_valid && !last_acc && !reset;
      end
      reset        = 1'b0;
      enable       = 1'b1;
      sample_valid = 1'b0;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
